// File: rtl/oc8051_cond_branch.sv
// Conditional-branch resolver: selects the comparator source, waits COMP_LAT
// cycles for it to settle, samples eq once and issues the branch decision/target.
module oc8051_cond_branch #(
  parameter int unsigned COMP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [3:0]  br_type,
  input  logic [15:0] pc_in,
  input  logic [7:0]  rel,
  input  logic        eq,
  output logic [1:0]  comp_sel,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [15:0] pc_out,
  output logic        pc_wr,
  output logic        bit_clr,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2
  } state_e;

  localparam logic [2:0] LAT = 3'(COMP_LAT);

  // Decode result packed as {legal, invert_eq, comp_sel[1:0]}.
  function automatic logic [3:0] dec(input logic [3:0] t);
    logic [3:0] r;
    case (t)
      4'd0:    r = 4'b1000;
      4'd1:    r = 4'b1100;
      4'd2:    r = 4'b1010;
      4'd3:    r = 4'b1110;
      4'd4:    r = 4'b1011;
      4'd5:    r = 4'b1111;
      4'd6:    r = 4'b1011;
      4'd7:    r = 4'b1101;
      4'd8:    r = 4'b1101;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  type_q, type_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  rel_q, rel_d;
  logic [1:0]  sel_q, sel_d;
  logic        done_q, done_d;
  logic        taken_q, taken_d;
  logic [15:0] pcout_q, pcout_d;
  logic        pc_wr_q, pc_wr_d;
  logic        bclr_q, bclr_d;
  logic        err_q, err_d;

  logic [3:0]  start_dec;
  logic [3:0]  eval_dec;
  logic        eval_taken;
  logic [15:0] target;

  assign start_dec  = dec(br_type);
  assign eval_dec   = dec(type_q);
  assign eval_taken = eval_dec[3] & (eq ^ eval_dec[2]);
  assign target     = pc_q + {{8{rel_q[7]}}, rel_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    pc_d    = pc_q;
    rel_d   = rel_q;
    sel_d   = sel_q;
    pcout_d = pcout_q;
    done_d  = 1'b0;
    taken_d = 1'b0;
    pc_wr_d = 1'b0;
    bclr_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // flush in the same cycle drops the request entirely
        if (start && !flush) begin
          state_d = S_WAIT;
          cnt_d   = LAT;
          type_d  = br_type;
          pc_d    = pc_in;
          rel_d   = rel;
          sel_d   = start_dec[1:0];
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          sel_d   = 2'b00;
        end else if (cnt_q <= 3'd1) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_EVAL: begin
        state_d = S_IDLE;
        sel_d   = 2'b00;
        if (!flush) begin
          done_d  = 1'b1;
          taken_d = eval_taken;
          pcout_d = eval_taken ? target : pc_q;
          pc_wr_d = eval_taken;
          bclr_d  = eval_taken && (type_q == 4'd6);
          err_d   = ~eval_dec[3];
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      type_q  <= 4'd0;
      pc_q    <= 16'd0;
      rel_q   <= 8'd0;
      sel_q   <= 2'b00;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      pcout_q <= 16'd0;
      pc_wr_q <= 1'b0;
      bclr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      pc_q    <= pc_d;
      rel_q   <= rel_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      pcout_q <= pcout_d;
      pc_wr_q <= pc_wr_d;
      bclr_q  <= bclr_d;
      err_q   <= err_d;
    end
  end

  assign comp_sel  = sel_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign taken     = taken_q;
  assign pc_out    = pcout_q;
  assign pc_wr     = pc_wr_q;
  assign bit_clr   = bclr_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_oc8051_cond_branch.sv
// Bench for oc8051_cond_branch: vector table on COMP_LAT=1 and COMP_LAT=3
// instances, random vectors, and hand-written flush/reset/back-to-back sequences.
module tb_oc8051_cond_branch;

  typedef struct {
    logic [3:0]  t;
    logic [15:0] pc;
    logic [7:0]  rel;
    logic        eq;
    logic [1:0]  sel;
    logic        tk;
    logic [15:0] po;
    logic        bc;
    logic        er;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, flush, eq;
  logic [3:0]  br_type;
  logic [15:0] pc_in;
  logic [7:0]  rel;
  logic        use3;

  logic [1:0]  d1_sel, d3_sel, d1_st, d3_st;
  logic        d1_busy, d1_done, d1_taken, d1_pc_wr, d1_bclr, d1_err;
  logic        d3_busy, d3_done, d3_taken, d3_pc_wr, d3_bclr, d3_err;
  logic [15:0] d1_pc, d3_pc;

  logic [1:0]  o_sel;
  logic        o_busy, o_done, o_taken, o_pc_wr, o_bclr, o_err;
  logic [15:0] o_pc;

  logic [18:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  vec_t tbl[14];

  always #5 clk = ~clk;

  oc8051_cond_branch #(.COMP_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .br_type(br_type),
    .pc_in(pc_in), .rel(rel), .eq(eq), .comp_sel(d1_sel), .busy(d1_busy),
    .done(d1_done), .taken(d1_taken), .pc_out(d1_pc), .pc_wr(d1_pc_wr),
    .bit_clr(d1_bclr), .err(d1_err), .state_dbg(d1_st)
  );

  oc8051_cond_branch #(.COMP_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .br_type(br_type),
    .pc_in(pc_in), .rel(rel), .eq(eq), .comp_sel(d3_sel), .busy(d3_busy),
    .done(d3_done), .taken(d3_taken), .pc_out(d3_pc), .pc_wr(d3_pc_wr),
    .bit_clr(d3_bclr), .err(d3_err), .state_dbg(d3_st)
  );

  assign o_sel   = use3 ? d3_sel   : d1_sel;
  assign o_busy  = use3 ? d3_busy  : d1_busy;
  assign o_done  = use3 ? d3_done  : d1_done;
  assign o_taken = use3 ? d3_taken : d1_taken;
  assign o_pc    = use3 ? d3_pc    : d1_pc;
  assign o_pc_wr = use3 ? d3_pc_wr : d1_pc_wr;
  assign o_bclr  = use3 ? d3_bclr  : d1_bclr;
  assign o_err   = use3 ? d3_err   : d1_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (lat%0d)", name, act, req, use3 ? 3 : 1);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".comp_sel"}, o_sel, 0);
    chk({name, ".busy"}, o_busy, 0);
    chk({name, ".done"}, o_done, 0);
    chk({name, ".taken"}, o_taken, 0);
    chk({name, ".pc_out"}, o_pc, 0);
    chk({name, ".pc_wr"}, o_pc_wr, 0);
    chk({name, ".bit_clr"}, o_bclr, 0);
    chk({name, ".err"}, o_err, 0);
  endtask

  // Pop the oldest expected result and compare against the done-cycle outputs.
  task automatic check_done(input string name);
    logic [18:0] e;
    if (exp_q.size() == 0) begin
      chk({name, ".unexpected_done"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({name, ".taken"}, o_taken, e[18]);
      chk({name, ".pc_out"}, o_pc, e[17:2]);
      chk({name, ".pc_wr"}, o_pc_wr, e[18]);
      chk({name, ".bit_clr"}, o_bclr, e[1]);
      chk({name, ".err"}, o_err, e[0]);
    end
  endtask

  task automatic watch_no_done(input string name, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      if (o_done) cnt++;
    end
    chk(name, cnt, 0);
  endtask

  task automatic run_vec(input vec_t v, input int lat, input string name);
    bit seen = 0;
    @(negedge clk);
    chk({name, ".idle_done"}, o_done, 0);
    br_type = v.t; pc_in = v.pc; rel = v.rel; eq = v.eq; start = 1'b1;
    exp_q.push_back({v.tk, v.po, v.bc, v.er});
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk({name, ".comp_sel"}, o_sel, v.sel);
    chk({name, ".busy"}, o_busy, 1);
    for (int k = 1; k <= lat + 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (o_done && !seen) begin
        seen = 1;
        chk({name, ".latency"}, k, lat + 1);
        check_done(name);
      end
    end
    chk({name, ".done_seen"}, seen, 1);
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    logic inv;
    logic legal = 1'b1;
    case (v.t)
      4'd0: begin r.sel = 2'b00; inv = 0; end
      4'd1: begin r.sel = 2'b00; inv = 1; end
      4'd2: begin r.sel = 2'b10; inv = 0; end
      4'd3: begin r.sel = 2'b10; inv = 1; end
      4'd4: begin r.sel = 2'b11; inv = 0; end
      4'd5: begin r.sel = 2'b11; inv = 1; end
      4'd6: begin r.sel = 2'b11; inv = 0; end
      4'd7, 4'd8: begin r.sel = 2'b01; inv = 1; end
      default: begin r.sel = 2'b00; inv = 0; legal = 1'b0; end
    endcase
    r.tk = legal && (inv ? !v.eq : v.eq);
    r.po = r.tk ? v.pc + {{8{v.rel[7]}}, v.rel} : v.pc;
    r.bc = r.tk && (v.t == 4'd6);
    r.er = !legal;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{4'd0,  16'h0100, 8'h10, 1'b1, 2'b00, 1'b1, 16'h0110, 1'b0, 1'b0};
    tbl[1]  = '{4'd1,  16'h0100, 8'h10, 1'b0, 2'b00, 1'b1, 16'h0110, 1'b0, 1'b0};
    tbl[2]  = '{4'd1,  16'h0100, 8'h10, 1'b1, 2'b00, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[3]  = '{4'd2,  16'h8000, 8'h80, 1'b1, 2'b10, 1'b1, 16'h7F80, 1'b0, 1'b0};
    tbl[4]  = '{4'd3,  16'hFFF0, 8'h20, 1'b0, 2'b10, 1'b1, 16'h0010, 1'b0, 1'b0};
    tbl[5]  = '{4'd4,  16'h0050, 8'h05, 1'b0, 2'b11, 1'b0, 16'h0050, 1'b0, 1'b0};
    tbl[6]  = '{4'd5,  16'h0050, 8'hFB, 1'b0, 2'b11, 1'b1, 16'h004B, 1'b0, 1'b0};
    tbl[7]  = '{4'd6,  16'h0300, 8'h02, 1'b1, 2'b11, 1'b1, 16'h0302, 1'b1, 1'b0};
    tbl[8]  = '{4'd7,  16'h0003, 8'hF0, 1'b0, 2'b01, 1'b1, 16'hFFF3, 1'b0, 1'b0};
    tbl[9]  = '{4'd7,  16'h0003, 8'hF0, 1'b1, 2'b01, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[10] = '{4'd8,  16'h1000, 8'h7F, 1'b0, 2'b01, 1'b1, 16'h107F, 1'b0, 1'b0};
    tbl[11] = '{4'd9,  16'h1000, 8'h10, 1'b1, 2'b00, 1'b0, 16'h1000, 1'b0, 1'b1};
    tbl[12] = '{4'd15, 16'h1000, 8'h10, 1'b0, 2'b00, 1'b0, 16'h1000, 1'b0, 1'b1};
    tbl[13] = '{4'd6,  16'h0300, 8'h02, 1'b0, 2'b11, 1'b0, 16'h0300, 1'b0, 1'b0};

    use3 = 1'b0; rst = 1'b1; start = 1'b1; flush = 1'b0; eq = 1'b0;
    br_type = 4'd0; pc_in = 16'h1234; rel = 8'h05;

    // Reset held two cycles with start asserted: everything stays zero.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      use3 = 1'b0; chk_idle("reset_d1");
      use3 = 1'b1; chk_idle("reset_d3");
    end
    rst = 1'b0; start = 1'b0; use3 = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], 1, $sformatf("tbl1_%0d", i));
    use3 = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 14; i++) run_vec(tbl[i], 3, $sformatf("tbl3_%0d", i));
    for (int i = 0; i < 16; i++) begin
      v.t = 4'($urandom_range(0, 15));
      v.pc = 16'($urandom_range(0, 65535));
      v.rel = 8'($urandom_range(0, 255));
      v.eq = 1'($urandom_range(0, 1));
      run_vec(model(v), 3, $sformatf("rnd_%0d", i));
    end

    // JBC with eq high only in the EVAL cycle; a start while busy is ignored.
    repeat (8) @(negedge clk);
    br_type = 4'd6; pc_in = 16'h1234; rel = 8'h05; eq = 1'b0; start = 1'b1;
    exp_q.push_back({1'b1, 16'h1239, 1'b1, 1'b0});
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("jbc.comp_sel", o_sel, 2'b11);
    @(posedge clk); @(negedge clk);
    chk("jbc.busy", o_busy, 1);
    start = 1'b1; br_type = 4'd0; pc_in = 16'h5555;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("jbc.early_done", o_done, 0);
    eq = 1'b1;
    @(posedge clk); @(negedge clk);
    eq = 1'b0;
    chk("jbc.done", o_done, 1);
    check_done("jbc");
    watch_no_done("jbc.single_done", 8);

    // Back-to-back on COMP_LAT=1: JC taken, then illegal type in the done cycle.
    use3 = 1'b0;
    repeat (4) @(negedge clk);
    br_type = 4'd2; pc_in = 16'h2000; rel = 8'h7F; eq = 1'b1; start = 1'b1;
    exp_q.push_back({1'b1, 16'h207F, 1'b0, 1'b0});
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("b2b.early_done", o_done, 0);
    @(posedge clk); @(negedge clk);
    chk("b2b.done1", o_done, 1);
    check_done("b2b1");
    br_type = 4'hC; pc_in = 16'h4000; rel = 8'h01; start = 1'b1;
    exp_q.push_back({1'b0, 16'h4000, 1'b0, 1'b1});
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("b2b.busy2", o_busy, 1);
    chk("b2b.sel_illegal", o_sel, 0);
    @(posedge clk); @(negedge clk);
    chk("b2b.early_done2", o_done, 0);
    @(posedge clk); @(negedge clk);
    chk("b2b.done2", o_done, 1);
    check_done("b2b2");

    // Flush during WAIT on COMP_LAT=3.
    use3 = 1'b1;
    repeat (8) @(negedge clk);
    br_type = 4'd1; pc_in = 16'h0100; rel = 8'h10; eq = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("flush.busy_before", o_busy, 1);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    chk("flush.busy_after", o_busy, 0);
    chk("flush.comp_sel", o_sel, 0);
    watch_no_done("flush.no_done", 6);

    // Flush together with start in IDLE drops the request.
    start = 1'b1; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_idle.busy", o_busy, 0);
    watch_no_done("flush_idle.no_done", 6);

    // Reset while in EVAL on COMP_LAT=3.
    br_type = 4'd7; pc_in = 16'h0003; rel = 8'hF0; eq = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("rst_eval.state", d3_st, 2'd2);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk_idle("rst_eval");
    watch_no_done("rst_eval.no_done", 6);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oc8051_cond_branch.md
Name: oc8051_cond_branch

Overview:
- Conditional-branch resolver; the consumer of the comparator's eq result.
- On a start request it latches the branch type and drives comp_sel to select the comparator source. It waits for the comparator to settle, samples eq, and decides taken/not-taken.
- Computes the relative target PC and issues a one-cycle PC write.
- Sits between the decoder (branch request), the comparator (eq), and the PC register (pc_out/pc_wr).

Parameters:
- COMP_LAT, 1, settle cycles between driving comp_sel and sampling eq; legal range 1..7.

Ports:
- clk       input   1   core clock
- rst       input   1   synchronous, active-high reset
- start     input   1   branch request; accepted only when busy=0
- flush     input   1   abort in-flight branch; no done is issued
- br_type   input   4   branch kind, latched on accepted start
- pc_in     input   16  address of the next sequential instruction, latched on start
- rel       input   8   signed relative offset, latched on start
- eq        input   1   comparator result
- comp_sel  output  2   comparator source select: AZ=00, DES=01, CY=10, BIT=11
- busy      output  1   high while a branch is in flight
- done      output  1   one-cycle completion pulse
- taken     output  1   branch decision; valid only while done=1
- pc_out    output  16  branch target; valid while done=1
- pc_wr     output  1   pulse: load pc_out into PC (done & taken)
- bit_clr   output  1   pulse: clear addressed bit (JBC taken only)
- err       output  1   pulse with done on an illegal br_type

Behaviour:
- One clock, clk. Reset is synchronous and active-high: rst is sampled only on the rising clk edge.
- Reset values: state=IDLE, and comp_sel, busy, done, taken, pc_out, pc_wr, bit_clr and err are all 0.
- rst asserted mid-operation: back to IDLE with all outputs 0 on the next edge. No done is issued.
- FSM states:
  - IDLE: start=1 latches br_type, pc_in and rel, and loads wait counter = COMP_LAT. Next state WAIT.
  - WAIT: counter decrements each cycle; on reaching 1, next state EVAL.
  - EVAL: sample eq, register the results, next state IDLE.
- Latency: done rises after edge COMP_LAT+1, counting the start-sampling edge as edge 0. It lasts exactly 1 cycle.
- busy = (state != IDLE). start while busy is ignored; it is not queued.
- Back-to-back: start is accepted in the IDLE cycle where done=1.
- comp_sel is registered and driven from the accepted start through EVAL; it is 00 in IDLE.
- Decode table (source, taken condition):
  - 0 JZ:   AZ, eq
  - 1 JNZ:  AZ, !eq
  - 2 JC:   CY, eq
  - 3 JNC:  CY, !eq
  - 4 JB:   BIT, eq
  - 5 JNB:  BIT, !eq
  - 6 JBC:  BIT, eq
  - 7 CJNE: DES, !eq
  - 8 DJNZ: DES, !eq
- br_type 9..15 is illegal:
  - comp_sel=00; the FSM still walks WAIT/EVAL.
  - On done: taken=0, pc_wr=0, err=1.
- Target arithmetic: pc_out = pc_in + sign_extend16(rel), modulo 2^16. Wrap-around both ways is legal with no flag.
- Not taken: pc_out = pc_in and pc_wr=0.
- pc_wr = done & taken. bit_clr = done & taken & (br_type==6). err is asserted only with done.
- done, taken, pc_wr, bit_clr and err are all registered and deasserted in every non-done cycle.
- flush:
  - In WAIT or EVAL: next state IDLE, no done.
  - In IDLE with start=1: flush wins and start is dropped.
  - flush and rst together: rst dominates, with the same result.
- eq is sampled only in EVAL. Changes of eq during WAIT have no effect.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 → every output is 0 and busy stays 0 throughout.
- JNZ taken, COMP_LAT=1: br_type=1, pc_in=16'h0100, rel=8'h10, eq=0 → comp_sel=00 from the cycle after start; done, taken and pc_wr high after edge 2; pc_out=16'h0110.
- CJNE backward wrap: br_type=7, pc_in=16'h0003, rel=8'hF0 (-16), eq=0 → comp_sel=01; pc_out=16'hFFF3; taken=1. Repeat with eq=1 → taken=0, pc_out=16'h0003, pc_wr=0.
- JBC and eq-sampling window, COMP_LAT=3: br_type=6, eq=0 during WAIT, eq=1 only in the EVAL cycle → done after edge 4; taken=1; bit_clr=1. A second start issued while busy is ignored, giving exactly one done pulse.
- Back-to-back and illegal type: JC with eq=1, then start asserted in the done cycle with br_type=4'hC → second done arrives COMP_LAT+1 edges later with err=1, taken=0, pc_wr=0.
- Flush and reset mid-flight: assert flush during WAIT → no done, busy drops next cycle. Assert rst during EVAL → no done, all outputs 0 after that edge.
